decode_stage: RTL and testbench

- Pipeline stage directly downstream of instruction fetch.
- Contains the IF/ID pipeline register (stall/flush control), the 32x32 integer register file and the RV32I immediate generator.
- Presents decoded operands and fields to the ID/EX register.
- Register-file write port is driven by the writeback stage, with internal WB-to-ID bypass.

---
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : decode_stage                                               |
// | Brief   : IF/ID register, 32x32 register file with WB bypass and      |
// |           RV32I immediate generator.                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_f_i,
  input  logic [XLEN-1:0] pc_f_i,
  input  logic [XLEN-1:0] pc_plus_4_f_i,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            reg_write_w,
  input  logic [4:0]      rd_w,
  input  logic [XLEN-1:0] result_w,
  output logic [31:0]     instr_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic [XLEN-1:0] pc_plus_4_d_o,
  output logic            valid_d_o,
  output logic [4:0]      rs1_d_o,
  output logic [4:0]      rs2_d_o,
  output logic [4:0]      rd_d_o,
  output logic [XLEN-1:0] rd1_d_o,
  output logic [XLEN-1:0] rd2_d_o,
  output logic [XLEN-1:0] imm_ext_d_o
);

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_plus_4;
  logic            r_valid;
  logic [XLEN-1:0] r_regs [32];
  logic            w_wb_en;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [31:0]     w_imm;

  // Flush outranks stall so a squashed instruction never lingers in ID.
  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      r_instr     <= NOP_INSTR;
      r_pc        <= '0;
      r_pc_plus_4 <= '0;
      r_valid     <= 1'b0;
    end else if (!stall_d) begin
      r_instr     <= instr_f_i;
      r_pc        <= pc_f_i;
      r_pc_plus_4 <= pc_plus_4_f_i;
      r_valid     <= 1'b1;
    end
  end

  assign w_wb_en = reg_write_w && (rd_w != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[rd_w] <= result_w;
    end
  end

  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];

  // Write-first read: a same-cycle WB write to the source is forwarded.
  always_comb begin
    rd1_d_o = '0;
    rd2_d_o = '0;
    if (w_rs1 != 5'd0) begin
      rd1_d_o = (w_wb_en && (rd_w == w_rs1)) ? result_w : r_regs[w_rs1];
    end
    if (w_rs2 != 5'd0) begin
      rd2_d_o = (w_wb_en && (rd_w == w_rs2)) ? result_w : r_regs[w_rs2];
    end
  end

  always_comb begin
    w_imm = '0;
    case (r_instr[6:0])
      c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM:
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      c_OP_STORE:
        w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      c_OP_BRANCH:
        w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                 r_instr[11:8], 1'b0};
      c_OP_LUI, c_OP_AUIPC:
        w_imm = {r_instr[31:12], 12'b0};
      c_OP_JAL:
        w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                 r_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign imm_ext_d_o   = XLEN'($signed(w_imm));
  assign instr_d_o     = r_instr;
  assign pc_d_o        = r_pc;
  assign pc_plus_4_d_o = r_pc_plus_4;
  assign valid_d_o     = r_valid;
  assign rs1_d_o       = w_rs1;
  assign rs2_d_o       = w_rs2;
  assign rd_d_o        = r_instr[11:7];

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_decode_stage                                            |
// | Brief   : Randomized scoreboard bench for decode_stage.              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f_i, pc_f_i, pc_plus_4_f_i;
  logic        stall_d, flush_d, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [31:0] instr_d_o, pc_d_o, pc_plus_4_d_o;
  logic        valid_d_o;
  logic [4:0]  rs1_d_o, rs2_d_o, rd_d_o;
  logic [31:0] rd1_d_o, rd2_d_o, imm_ext_d_o;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .instr_f_i(instr_f_i), .pc_f_i(pc_f_i),
    .pc_plus_4_f_i(pc_plus_4_f_i), .stall_d(stall_d), .flush_d(flush_d),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
    .instr_d_o(instr_d_o), .pc_d_o(pc_d_o), .pc_plus_4_d_o(pc_plus_4_d_o),
    .valid_d_o(valid_d_o), .rs1_d_o(rs1_d_o), .rs2_d_o(rs2_d_o),
    .rd_d_o(rd_d_o), .rd1_d_o(rd1_d_o), .rd2_d_o(rd2_d_o),
    .imm_ext_d_o(imm_ext_d_o)
  );

  typedef struct {
    logic [31:0] instr, pc, pc4;
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rd1, rd2, imm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: what ID holds and what the architectural registers hold.
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_regs [32];
  bit          m_init = 0;

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    logic [31:0] sgn;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73:
        return (sgn << 11) | 32'(ins[30:20]);
      7'h23:
        return (sgn << 11) | (32'(ins[30:25]) << 5) | 32'(ins[11:7]);
      7'h63:
        return (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
             | (32'(ins[11:8]) << 1);
      7'h37, 7'h17:
        return ins & 32'hFFFF_F000;
      7'h6F:
        return (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
             | (32'(ins[30:21]) << 1);
      default:
        return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] src, input logic we,
                                             input logic [4:0] dst, input logic [31:0] res);
    if (src == 5'd0) return 32'h0;
    if (we && dst == src) return res;
    return m_regs[src];
  endfunction

  task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic st,
                      input logic fl, input logic we, input logic [4:0] dst,
                      input logic [31:0] res, input logic r);
    exp_t e;
    @(negedge clk);
    instr_f_i = ins; pc_f_i = pc; pc_plus_4_f_i = pc + 32'd4;
    stall_d = st; flush_d = fl; reg_write_w = we; rd_w = dst; result_w = res; rst = r;
    if (m_init) begin
      e.instr = m_instr; e.pc = m_pc; e.pc4 = m_pc4; e.valid = m_valid;
      e.rs1 = m_instr[19:15]; e.rs2 = m_instr[24:20]; e.rd = m_instr[11:7];
      e.rd1 = model_read(m_instr[19:15], we, dst, res);
      e.rd2 = model_read(m_instr[24:20], we, dst, res);
      e.imm = model_imm(m_instr);
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'h0;
      m_instr = 32'h13; m_pc = 0; m_pc4 = 0; m_valid = 0;
    end else begin
      if (we && dst != 5'd0) m_regs[dst] = res;
      if (fl) begin
        m_instr = 32'h13; m_pc = 0; m_pc4 = 0; m_valid = 0;
      end else if (!st) begin
        m_instr = ins; m_pc = pc; m_pc4 = pc + 32'd4; m_valid = 1;
      end
    end
    m_init = 1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a decoded bundle; compare it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("instr", instr_d_o, e.instr);
        check("pc", pc_d_o, e.pc);
        check("pc4", pc_plus_4_d_o, e.pc4);
        check("valid", 32'(valid_d_o), 32'(e.valid));
        check("rs1", 32'(rs1_d_o), 32'(e.rs1));
        check("rs2", 32'(rs2_d_o), 32'(e.rs2));
        check("rd", 32'(rd_d_o), 32'(e.rd));
        check("rd1", rd1_d_o, e.rd1);
        check("rd2", rd2_d_o, e.rd2);
        check("imm", imm_ext_d_o, e.imm);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] ins;
    logic [4:0]  dst;
    ops = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    rst = 1; instr_f_i = 32'hFFFF_FFFF; pc_f_i = 0; pc_plus_4_f_i = 4;
    stall_d = 0; flush_d = 0; reg_write_w = 0; rd_w = 0; result_w = 0;

    step(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 0, 1);
    step(32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 0, 1);
    step(32'hFFF0_0093, 32'h0, 0, 0, 0, 0, 0, 0);
    step(32'hFE00_0EE3, 32'h4, 0, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h10, 0, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h14, 1, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h14, 1, 1, 0, 0, 0, 0);
    step(32'h0002_8093, 32'h20, 0, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h24, 1, 0, 1, 5'd5, 32'hDEAD_BEEF, 0);
    step(32'h0000_0013, 32'h24, 1, 0, 0, 0, 0, 0);
    step(32'h0000_0093, 32'h30, 0, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h34, 1, 0, 1, 5'd0, 32'h1234, 0);
    step(32'h0000_0013, 32'h34, 1, 0, 0, 0, 0, 0);
    step(32'h0062_80B3, 32'h40, 0, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h44, 1, 0, 0, 0, 0, 0);
    step(32'h0000_0013, 32'h44, 1, 0, 1, 5'd6, 32'hCAFE_F00D, 1);
    step(32'h0000_0013, 32'h44, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 3))
        0: dst = m_instr[19:15];
        1: dst = m_instr[24:20];
        default: dst = 5'($urandom);
      endcase
      step(ins, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1), dst, $urandom, ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    #5;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
